// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch stage
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INC    = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction-memory bus and IF/ID register bundle
interface fetch_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    import fetch_pkg::*;

    logic [PC_W-1:0]  ImemAddr;
    logic             ImemEn;
    logic [INS_W-1:0] ImemRdata;
    logic [PC_W-1:0]  IfId_PC;
    logic [INS_W-1:0] IfId_Instr;
    logic             IfId_Valid;

    modport master (
        output ImemAddr, ImemEn, IfId_PC, IfId_Instr, IfId_Valid,
        input  ImemRdata
    );

    modport slave (
        input  ImemAddr, ImemEn, IfId_PC, IfId_Instr, IfId_Valid,
        output ImemRdata
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating fetch and flush event counters
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc_i,
    input  logic        flush_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o
);
    import fetch_pkg::*;

    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    // Count events, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_inc_i && (fetch_cnt_q != 32'hFFFF_FFFF))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flush_inc_i && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, IF/ID register and RUN/HALT control; FETCH_PERF_CNT_EN adds event counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PcSel,
    input  logic [31:0] BrPC,
    input  logic        Halt,
    input  logic        Resume,
    input  logic        PcStall,
    fetch_if.master     bus,
    output logic        Halted,
    output logic        MisalignErr,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [INS_W-1:0] ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic             misalign_q, misalign_d;

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  br_target;
    logic             unused_brpc_hi;

    // Upper target bits lie outside the instruction-memory space
    assign unused_brpc_hi = ^BrPC[31:PC_W];

    assign pc_inc    = pc_q + PC_W'(PC_INC);
    assign br_target = {BrPC[PC_W-1:2], 2'b00};

    // Next state, next PC and IF/ID contents by redirect/stall priority
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = misalign_q | (PcSel && (BrPC[1:0] != 2'b00));

        unique case (state_q)
            HALT: begin
                // EX is empty while halted, so PcSel carries no meaning here
                ifid_pc_d    = pc_q;
                ifid_instr_d = INS_W'(NOP_INSTR);
                ifid_valid_d = 1'b0;
                if (Resume) begin
                    state_d = RUN;
                    pc_d    = pc_inc;
                end
            end
            default: begin
                if (PcSel) begin
                    pc_d         = br_target;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = INS_W'(NOP_INSTR);
                    ifid_valid_d = 1'b0;
                    if (Halt)
                        state_d = HALT;
                end else if (!PcStall) begin
                    pc_d         = pc_inc;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = bus.ImemRdata;
                    ifid_valid_d = 1'b1;
                end
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= INS_W'(NOP_INSTR);
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign bus.ImemAddr   = pc_q;
    assign bus.ImemEn     = (state_q == RUN);
    assign bus.IfId_PC    = ifid_pc_q;
    assign bus.IfId_Instr = ifid_instr_q;
    assign bus.IfId_Valid = ifid_valid_q;
    assign Halted         = (state_q == HALT);
    assign MisalignErr    = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic flush_inc;

    assign fetch_inc = (state_q == RUN) && !PcSel && !PcStall;
    assign flush_inc = (state_q == RUN) && PcSel;

    fetch_perf_cnt u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc_i (fetch_inc),
        .flush_inc_i (flush_inc),
        .fetch_cnt_o (FetchCount),
        .flush_cnt_o (FlushCount)
    );
`else
    assign FetchCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized check of fetch_unit against a behavioural model
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int PC_MOD = 1 << PC_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PcSel = 1'b0;
    logic [31:0] BrPC = '0;
    logic        Halt = 1'b0;
    logic        Resume = 1'b0;
    logic        PcStall = 1'b0;
    logic        Halted;
    logic        MisalignErr;
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;

    fetch_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

    // Memory returns its own address as the instruction word
    assign bus.ImemRdata = INS_W'(bus.ImemAddr);

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .INS_W(INS_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PcSel       (PcSel),
        .BrPC        (BrPC),
        .Halt        (Halt),
        .Resume      (Resume),
        .PcStall     (PcStall),
        .bus         (bus),
        .Halted      (Halted),
        .MisalignErr (MisalignErr),
        .FetchCount  (FetchCount),
        .FlushCount  (FlushCount)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit          m_halt;
    int unsigned m_pc, m_ifpc;
    logic [31:0] m_ifins;
    bit          m_ifv, m_mis;
    logic [31:0] m_fc, m_flc;

    task automatic model_reset();
        m_halt = 0; m_pc = 0; m_ifpc = 0; m_ifins = 32'h13;
        m_ifv = 0; m_mis = 0; m_fc = 0; m_flc = 0;
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".addr"},  64'(bus.ImemAddr),   64'(m_pc));
        check({tag, ".en"},    64'(bus.ImemEn),     64'(!m_halt));
        check({tag, ".halt"},  64'(Halted),         64'(m_halt));
        check({tag, ".ifpc"},  64'(bus.IfId_PC),    64'(m_ifpc));
        check({tag, ".ifins"}, 64'(bus.IfId_Instr), 64'(m_ifins));
        check({tag, ".ifv"},   64'(bus.IfId_Valid), 64'(m_ifv));
        check({tag, ".mis"},   64'(MisalignErr),    64'(m_mis));
`ifdef FETCH_PERF_CNT_EN
        check({tag, ".fcnt"},  64'(FetchCount),     64'(m_fc));
        check({tag, ".flcnt"}, 64'(FlushCount),     64'(m_flc));
`else
        check({tag, ".fcnt"},  64'(FetchCount),     64'd0);
        check({tag, ".flcnt"}, 64'(FlushCount),     64'd0);
`endif
    endtask

    // Advance model and DUT by one clock with the currently driven inputs
    task automatic cycle(input string tag);
        bit          n_halt = m_halt;
        int unsigned n_pc = m_pc, n_ifpc = m_ifpc;
        logic [31:0] n_ifins = m_ifins;
        bit          n_ifv = m_ifv;
        logic [31:0] n_fc = m_fc, n_flc = m_flc;
        if (m_halt) begin
            n_ifpc = m_pc; n_ifins = 32'h13; n_ifv = 0;
            if (Resume) begin
                n_halt = 0;
                n_pc = (m_pc + 4) % PC_MOD;
            end
        end else if (PcSel) begin
            n_pc = (BrPC % PC_MOD) & ~32'd3;
            n_halt = Halt;
            n_ifpc = m_pc; n_ifins = 32'h13; n_ifv = 0;
            n_flc = sat_inc(m_flc);
        end else if (!PcStall) begin
            n_ifpc = m_pc; n_ifins = m_pc; n_ifv = 1;
            n_pc = (m_pc + 4) % PC_MOD;
            n_fc = sat_inc(m_fc);
        end
        if (PcSel && (BrPC % 4 != 0)) m_mis = 1;
        @(posedge clk);
        #1;
        m_halt = n_halt; m_pc = n_pc; m_ifpc = n_ifpc; m_ifins = n_ifins;
        m_ifv = n_ifv; m_fc = n_fc; m_flc = n_flc;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        PcSel = 0; Halt = 0; Resume = 0; PcStall = 0; BrPC = '0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1;

        // Free run to PC 0x10
        repeat (4) cycle("run");
        check("run.pc10", 64'(bus.ImemAddr), 64'h10);

        // Taken branch
        PcSel = 1; BrPC = 32'h40;
        cycle("br");
        check("br.target", 64'(bus.ImemAddr), 64'h40);
        check("br.bubble", 64'(bus.IfId_Valid), 64'd0);
        idle_inputs();
        cycle("br1");
        check("br.ifpc", 64'(bus.IfId_PC), 64'h40);
        repeat (2) cycle("br2");

        // Stall then redirect together with stall
        PcStall = 1;
        repeat (2) cycle("stall");
        PcSel = 1; BrPC = 32'h80;
        cycle("stallbr");
        check("stallbr.pc", 64'(bus.ImemAddr), 64'h80);
        idle_inputs();
        repeat (2) cycle("stallbr2");

        // Halt and resume
        PcSel = 1; Halt = 1; BrPC = 32'h24;
        cycle("halt");
        idle_inputs();
        repeat (10) cycle("halted");
        check("halt.pc", 64'(bus.ImemAddr), 64'h24);
        Resume = 1; PcSel = 1; BrPC = 32'h100;
        cycle("resume");
        check("resume.pc", 64'(bus.ImemAddr), 64'h28);
        idle_inputs();
        repeat (3) cycle("resumed");

        // Wrap past the top of the address space
        PcSel = 1; BrPC = 32'h1F4;
        cycle("wrapbr");
        idle_inputs();
        repeat (3) cycle("wrap");
        check("wrap.zero", 64'(bus.ImemAddr), 64'h0);
        cycle("wrap2");

        // Misaligned redirect sets a sticky flag
        PcSel = 1; BrPC = 32'h33;
        cycle("mis");
        check("mis.pc", 64'(bus.ImemAddr), 64'h30);
        idle_inputs();
        repeat (3) cycle("missticky");

        // Asynchronous reset mid-run, then again while halted
        @(negedge clk);
        #2 rst_n = 0;
        #1 model_reset();
        compare_all("arst_run");
        @(negedge clk) rst_n = 1;
        cycle("post_rst");
        PcSel = 1; Halt = 1; BrPC = 32'h1C;
        cycle("halt2");
        idle_inputs();
        cycle("halt2b");
        @(negedge clk);
        #2 rst_n = 0;
        #1 model_reset();
        compare_all("arst_halt");
        @(negedge clk) rst_n = 1;
        repeat (2) cycle("post_rst2");

`ifdef FETCH_PERF_CNT_EN
        // Counter saturation
        @(negedge clk);
        force dut.u_perf.fetch_cnt_q = 32'hFFFF_FFFD;
        #1 release dut.u_perf.fetch_cnt_q;
        m_fc = 32'hFFFF_FFFD;
        repeat (5) cycle("sat");
        check("sat.fcnt", 64'(FetchCount), 64'hFFFF_FFFF);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            PcSel   = ($urandom_range(0, 7) == 0);
            Halt    = PcSel && ($urandom_range(0, 2) == 0);
            Resume  = ($urandom_range(0, 5) == 0);
            PcStall = ($urandom_range(0, 3) == 0);
            BrPC    = $urandom;
            cycle("rand");
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
